alu_share_sched: RTL and testbench
==================================

// Module: alu_share_sched
// PURPOSE
//  Two-requester scheduler that time-shares one 32-bit alu instance (registered outputs, 1-cycle latency).
//  Arbitrates round-robin, latches the winner's operands/control, sequences the ALU and returns flags to the owner.
//  Sits between two datapath clients and the single alu; sole driver of all alu inputs.
// PARAMETERS
//  DATA_W  32  operand/result width; must match alu
//  CTRL_W  4   ALU_control width
//  CNT_W   16  grant counter width (ALU_SHARE_STATS_EN only)
// PORTS
//  clk           in   1       system clock; all state on posedge
//  rst           in   1       synchronous, active-high reset
//  reqN_valid    in   1       N=0,1: request pending; held until accepted
//  reqN_ready    out  1       N=0,1: request accepted this cycle
//  reqN_src1     in   DATA_W  N=0,1: operand 1
//  reqN_src2     in   DATA_W  N=0,1: operand 2
//  reqN_ctrl     in   CTRL_W  N=0,1: ALU_control code
//  rspN_valid    out  1       N=0,1: response for requester N held
//  rspN_ready    in   1       N=0,1: requester N consumes response
//  rsp_result    out  DATA_W  shared response result
//  rsp_zero/rsp_cout/rsp_ovf  out 1 each  shared response flags
//  alu_rst_n     out  1       to alu rst_n; = ~rst
//  alu_src1/alu_src2 out DATA_W; alu_ctrl out CTRL_W: registered operands to alu
//  alu_result in DATA_W; alu_zero/alu_cout/alu_ovf in 1: alu outputs
// BEHAVIOUR
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; owner reg (1b), prio ptr (1b).
//  IDLE: grant = both valid ? prio : whichever valid. reqN_ready = (IDLE && grant==N), combinational;
//   never both high. On accept edge: alu_src1/src2/ctrl <= winner operands, owner <= N, -> ISSUE.
//  ISSUE: alu inputs stable; alu samples on this edge; -> WAIT.
//  WAIT: capture alu_result/zero/cout/ovf into rsp_* regs, rspN_valid(owner) <= 1; -> RESP.
//  RESP: hold rsp_* and rspN_valid until rspN_ready(owner)=1; on that edge rspN_valid <= 0,
//   prio <= ~owner, -> IDLE. rspN_ready of non-owner ignored.
//  Latency: rsp valid 2 cycles after accept edge (visible in 3rd cycle). Min 4 cycles/op; no overlap.
//  No new request accepted outside IDLE; reqN_valid in any other state only waits.
//  Prio only changes after a completed response: sole requester may win repeatedly.
//  alu_* inputs retain last operands when idle (no toggling).
//  Reset (any state, incl. mid-op): state=IDLE, prio=0, owner=0, rsp0/1_valid=0, reqN_ready=0,
//   rsp_*=0, alu_src1/src2/ctrl=0; in-flight op discarded, no response issued. alu_rst_n=0 while rst.
//  Widths: results passed through unmodified; no arithmetic performed here.
// CONFIGURATION
//  ALU_SHARE_STATS_EN defined: adds outputs gnt0_cnt, gnt1_cnt (CNT_W each); incremented on every
//   accept of that requester, wrap at 2^CNT_W-1 -> 0, cleared by rst.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  Reset mid-WAIT with req0 op -> next cycle IDLE, rsp0_valid=0, no response ever for that op.
//  req0 only, src1=5 src2=3 ctrl=ADD(0010), rsp0_ready=1 -> rsp0_valid 2 cyc after accept, result=8, zero=0.
//  req0,req1 both valid after reset: req0 SUB 7-7, req1 OR -> req0 served first (zero=1), then req1; alternates.
//  rsp0_ready held 0 for 5 cycles -> rsp0_valid and rsp_result stable, req1_ready stays 0 throughout.
//  req1 ADD 0x7FFFFFFF+1 -> result 0x80000000, ovf=1, cout=0; rsp1_valid only, rsp0_valid=0.
//  STATS_EN, CNT_W=2: 5 accepts of req0 -> gnt0_cnt=1 (wrapped), gnt1_cnt=0.

Source files
------------

// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin scheduler that time-shares one registered
// 32-bit ALU (1-cycle latency) between two requesters. It latches the winning
// operands, lets the ALU sample them, captures the flags and holds the
// response until the owner consumes it. Only one operation is in flight at a time.
// Optional feature: define ALU_SHARE_STATS_EN to add per-requester grant
// counters (gnt0_cnt, gnt1_cnt).
module alu_share_sched #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
`ifdef ALU_SHARE_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_cout,
  output logic              rsp_ovf,
  output logic              alu_rst_n,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_cout,
  input  logic              alu_ovf
`ifdef ALU_SHARE_STATS_EN
  , output logic [CNT_W-1:0] gnt0_cnt
  , output logic [CNT_W-1:0] gnt1_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                prio_q, prio_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_zero_q, rsp_zero_d;
  logic                rsp_cout_q, rsp_cout_d;
  logic                rsp_ovf_q, rsp_ovf_d;
  logic [DATA_W-1:0]   alu_src1_q, alu_src1_d;
  logic [DATA_W-1:0]   alu_src2_q, alu_src2_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic                grant;
  logic                own_ready;

  // Winner when both request is the priority pointer, otherwise the lone requester.
  assign grant     = (req0_valid && req1_valid) ? prio_q : req1_valid;
  assign own_ready = owner_q ? rsp1_ready : rsp0_ready;

  // Next-state, arbitration and capture logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    prio_d       = prio_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_ovf_d    = rsp_ovf_q;
    alu_src1_d   = alu_src1_q;
    alu_src2_d   = alu_src2_q;
    alu_ctrl_d   = alu_ctrl_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is suppressed during reset so nothing is accepted on a reset edge.
        if ((req0_valid || req1_valid) && !rst) begin
          req0_ready = ~grant;
          req1_ready = grant;
          owner_d    = grant;
          alu_src1_d = grant ? req1_src1 : req0_src1;
          alu_src2_d = grant ? req1_src2 : req0_src2;
          alu_ctrl_d = grant ? req1_ctrl : req0_ctrl;
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_cout_d   = alu_cout;
        rsp_ovf_d    = alu_ovf;
        if (owner_q) rsp1_valid_d = 1'b1;
        else         rsp0_valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (own_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          prio_d       = ~owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      prio_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_cout_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      alu_src1_q   <= '0;
      alu_src2_q   <= '0;
      alu_ctrl_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      prio_q       <= prio_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_ovf_q    <= rsp_ovf_d;
      alu_src1_q   <= alu_src1_d;
      alu_src2_q   <= alu_src2_d;
      alu_ctrl_q   <= alu_ctrl_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign alu_src1   = alu_src1_q;
  assign alu_src2   = alu_src2_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign alu_rst_n  = ~rst;

`ifdef ALU_SHARE_STATS_EN
  logic [1:0] accept;
  assign accept = {req1_ready, req0_ready};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    // Grant counter: counts accepts of requester gi, wraps naturally.
    always_ff @(posedge clk) begin
      if (rst)             cnt_q <= '0;
      else if (accept[gi]) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign gnt0_cnt = g_cnt[0].cnt_q;
  assign gnt1_cnt = g_cnt[1].cnt_q;
`endif

endmodule

// File: tb/tb_alu_share_sched.sv
// Testbench for alu_share_sched: behavioural ALU stub, transaction-level
// reference model with a per-cycle compare, and directed literal checks.
module tb_alu_share_sched;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_cout, rsp_ovf;
  logic        alu_rst_n;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero, alu_cout, alu_ovf;
`ifdef ALU_SHARE_STATS_EN
  logic [1:0]  gnt0_cnt, gnt1_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_sched #(
    .DATA_W(32),
    .CTRL_W(4)
`ifdef ALU_SHARE_STATS_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .alu_rst_n(alu_rst_n), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout), .alu_ovf(alu_ovf)
`ifdef ALU_SHARE_STATS_EN
    , .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
`endif
  );

  // ALU function: returns {ovf, cout, zero, result}.
  function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic        co, ov;
    s = 33'd0; co = 1'b0; ov = 1'b0;
    case (c)
      C_AND: r = a & b;
      C_OR:  r = a | b;
      C_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      C_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: r = 32'd0;
    endcase
    return {ov, co, (r == 32'd0), r};
  endfunction

  // Behavioural ALU with registered outputs and active-low reset.
  always @(posedge clk) begin
    if (!alu_rst_n) {alu_ovf, alu_cout, alu_zero, alu_result} <= 35'd0;
    else            {alu_ovf, alu_cout, alu_zero, alu_result} <= alu_fn(alu_src1, alu_src2, alu_ctrl);
  end

  // Reference model: one op at a time, response two edges after acceptance.
  bit          m_ok = 1'b0;
  bit          m_idle, m_owner, m_prio, m_rsp_v;
  int          m_age;
  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_c;
  logic        m_zero, m_cout, m_ovf;

  function automatic bit m_any();
    return !rst && m_idle && (req0_valid || req1_valid);
  endfunction
  function automatic bit m_win();
    return (req0_valid && req1_valid) ? m_prio : req1_valid;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ok <= 1'b1; m_idle <= 1'b1; m_owner <= 1'b0; m_prio <= 1'b0; m_rsp_v <= 1'b0;
      m_age <= 0; m_a <= '0; m_b <= '0; m_c <= '0;
      m_res <= '0; m_zero <= 1'b0; m_cout <= 1'b0; m_ovf <= 1'b0;
    end else if (m_ok) begin
      if (m_idle) begin
        if (m_any()) begin
          m_owner <= m_win();
          m_a <= m_win() ? req1_src1 : req0_src1;
          m_b <= m_win() ? req1_src2 : req0_src2;
          m_c <= m_win() ? req1_ctrl : req0_ctrl;
          m_idle <= 1'b0;
          m_age <= 1;
        end
      end else if (!m_rsp_v) begin
        if (m_age == 2) begin
          {m_ovf, m_cout, m_zero, m_res} <= alu_fn(m_a, m_b, m_c);
          m_rsp_v <= 1'b1;
        end else begin
          m_age <= m_age + 1;
        end
      end else if (m_owner ? rsp1_ready : rsp0_ready) begin
        m_rsp_v <= 1'b0;
        m_prio  <= !m_owner;
        m_idle  <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_req0_ready", 32'(req0_ready), 32'(m_any() && !m_win()));
      chk("m_req1_ready", 32'(req1_ready), 32'(m_any() && m_win()));
      chk("m_rsp0_valid", 32'(rsp0_valid), 32'(m_rsp_v && !m_owner));
      chk("m_rsp1_valid", 32'(rsp1_valid), 32'(m_rsp_v && m_owner));
      chk("m_rsp_result", rsp_result, m_res);
      chk("m_rsp_flags", {29'd0, rsp_ovf, rsp_cout, rsp_zero}, {29'd0, m_ovf, m_cout, m_zero});
      chk("m_alu_src1", alu_src1, m_a);
      chk("m_alu_src2", alu_src2, m_b);
      chk("m_alu_ctrl", 32'(alu_ctrl), 32'(m_c));
      chk("m_alu_rst_n", 32'(alu_rst_n), 32'(!rst));
    end
  end

  // Present a request and hold it until accepted (bounded).
  task automatic issue(input int n, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c);
    bit got = 1'b0;
    @(posedge clk); #1;
    if (n == 0) begin req0_src1 = a; req0_src2 = b; req0_ctrl = c; req0_valid = 1'b1; end
    else        begin req1_src1 = a; req1_src2 = b; req1_ctrl = c; req1_valid = 1'b1; end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (n == 0) ? req0_ready : req1_ready;
    end
    chk("accept_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    $display("txn: req%0d ctrl=%b src1=0x%08h src2=0x%08h accepted=%0d", n, c, a, b, got);
  endtask

  // Count negedges from the accept edge until rspN_valid is seen (bounded).
  task automatic wait_rsp(input int n, output int lat);
    bit got = 1'b0;
    lat = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      lat++;
      got = (n == 0) ? rsp0_valid : rsp1_valid;
    end
    chk("rsp_seen", 32'(got), 32'd1);
    $display("txn: rsp%0d result=0x%08h z=%0d c=%0d v=%0d latency=%0d",
             n, rsp_result, rsp_zero, rsp_cout, rsp_ovf, lat);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  // Both requesters valid together; checks service order and results.
  task automatic both(input int first);
    int order[2];
    int n_acc = 0;
    bit a0, a1, s0 = 1'b0, s1 = 1'b0;
    @(posedge clk); #1;
    req0_src1 = 32'd7;    req0_src2 = 32'd7;    req0_ctrl = C_SUB; req0_valid = 1'b1;
    req1_src1 = 32'h00F0; req1_src2 = 32'h000F; req1_ctrl = C_OR;  req1_valid = 1'b1;
    for (int k = 0; k < 40 && !(s0 && s1); k++) begin
      @(negedge clk);
      a0 = req0_ready; a1 = req1_ready;
      if (a0 && n_acc < 2) begin order[n_acc] = 0; n_acc++; end
      if (a1 && n_acc < 2) begin order[n_acc] = 1; n_acc++; end
      if (rsp0_valid && !s0) begin
        s0 = 1'b1;
        chk("sub_result", rsp_result, 32'd0);
        chk("sub_zero", 32'(rsp_zero), 32'd1);
        $display("txn: rsp0 SUB 7-7 result=0x%08h z=%0d", rsp_result, rsp_zero);
      end
      if (rsp1_valid && !s1) begin
        s1 = 1'b1;
        chk("or_result", rsp_result, 32'h00FF);
        chk("or_zero", 32'(rsp_zero), 32'd0);
        $display("txn: rsp1 OR result=0x%08h z=%0d", rsp_result, rsp_zero);
      end
      @(posedge clk); #1;
      if (a0) req0_valid = 1'b0;
      if (a1) req1_valid = 1'b0;
    end
    chk("both_accepts", 32'(n_acc), 32'd2);
    chk("first_served", 32'(order[0]), 32'(first));
    chk("second_served", 32'(order[1]), 32'(1 - first));
  endtask

  initial begin
    int lat;
    bit got;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_src1 = '0; req0_src2 = '0; req0_ctrl = '0;
    req1_src1 = '0; req1_src2 = '0; req1_ctrl = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_alu_rst_n", 32'(alu_rst_n), 32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_alu_src1", alu_src1, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Reset mid-WAIT: the in-flight op must vanish without a response.
    issue(0, 32'd1, 32'd2, C_ADD);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      got = got | rsp0_valid;
    end
    chk("midop_reset_no_rsp", 32'(got), 32'd0);
    $display("txn: reset mid-op, response seen=%0d", got);

    // Single ADD, latency and result.
    issue(0, 32'd5, 32'd3, C_ADD);
    wait_rsp(0, lat);
    chk("add_latency", 32'(lat), 32'd3);
    chk("add_result", rsp_result, 32'd8);
    chk("add_zero", 32'(rsp_zero), 32'd0);

    // Fresh reset, then contention twice: req0 wins both times.
    do_reset();
    both(0);
    both(0);

    // Owner stalls response: output held, req1 locked out.
    req1_src1 = 32'h1234_0000; req1_src2 = 32'h0000_5678; req1_ctrl = C_OR;
    req1_valid = 1'b1;
    rsp0_ready = 1'b0;
    issue(0, 32'h0000_FF00, 32'h0000_0FF0, C_AND);
    wait_rsp(0, lat);
    for (int k = 0; k < 5; k++) begin
      chk("stall_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("stall_result", rsp_result, 32'h0000_0F00);
      chk("stall_req1_ready", 32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1; rsp0_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      got = req1_ready;
    end
    chk("req1_after_stall", 32'(got), 32'd1);
    @(posedge clk); #1; req1_valid = 1'b0;
    wait_rsp(1, lat);
    chk("stall_or_result", rsp_result, 32'h1234_5678);

    // Signed overflow on requester 1.
    issue(1, 32'h7FFF_FFFF, 32'd1, C_ADD);
    wait_rsp(1, lat);
    chk("ovf_result", rsp_result, 32'h8000_0000);
    chk("ovf_flag", 32'(rsp_ovf), 32'd1);
    chk("ovf_cout", 32'(rsp_cout), 32'd0);
    chk("ovf_rsp0_quiet", 32'(rsp0_valid), 32'd0);

`ifdef ALU_SHARE_STATS_EN
    // Counter wrap with a 2-bit counter.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      issue(0, 32'(k), 32'd1, C_ADD);
      wait_rsp(0, lat);
    end
    @(negedge clk);
    chk("gnt0_cnt_wrap", 32'(gnt0_cnt), 32'd1);
    chk("gnt1_cnt_zero", 32'(gnt1_cnt), 32'd0);
`endif

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
